lsu_bus_master: RTL and testbench

- Load/store unit on the core side of the data-memory interface: the initiator of every LB/LH/LW/LBU/LHU/SB/SH/SW access.
- Accepts one request from the execute stage and issues a word-addressed, byte-enabled request on a valid/grant memory bus.
- Waits for load data, then sign- or zero-extends it and returns a single-cycle response pulse to writeback.
- Holds the pipeline with `req_ready_o` while an access is outstanding. A timeout counter ends any access the memory never completes.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/lsu_bus_master_if.sv | 24 ++
 rtl/lsu_align.sv | 50 +++++
 rtl/lsu_bus_master.sv | 132 +++++++++++++
 tb/tb_lsu_bus_master.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store bus master.
// funct3 decode, FSM states and alignment helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  function automatic logic f3_illegal(
    input logic       store,
    input logic [2:0] f3
  );
    if (store)
      return f3[2] | (f3[1] & f3[0]);
    return (f3[1] & f3[0]) | (f3[2] & f3[1]);
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    return ((f3[1:0] == 2'b01) & off[0]) |
           ((f3 == F3_W) & (|off));
  endfunction

  function automatic logic [1:0] force_align(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    unique case (1'b1)
      f3[1:0] == 2'b01: return {off[1], 1'b0};
      f3 == F3_W:       return 2'b00;
      default:          return off;
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_master_if.sv
// Word-addressed valid/grant data-memory bus.
// master drives the request side, slave answers grant and read data.
interface lsu_bus_master_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [29:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o,
    output mem_be_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o,
    input  mem_be_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store enables/replication and load extraction.
// Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rword[7:0];
    unique case (off)
      2'd1:    byte_sel = rword[15:8];
      2'd2:    byte_sel = rword[23:16];
      2'd3:    byte_sel = rword[31:24];
      default: byte_sel = rword[7:0];
    endcase
    half_sel = off[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    rdata_ext = rword;
    unique case (1'b1)
      func3[1:0] == 2'b00: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = func3[2] ? {24'b0, byte_sel}
                             : {{24{byte_sel[7]}}, byte_sel};
      end
      func3[1:0] == 2'b01: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = func3[2] ? {16'b0, half_sel}
                             : {{16{half_sel[15]}}, half_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus_master.sv
// Load/store unit master on the data-memory valid/grant bus.
// LSU_MISALIGN_TRAP_EN: trap misaligned H/W instead of force-aligning.
module lsu_bus_master
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_func3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        bus_err_o,
  lsu_bus_master_if.master bus
);

  lsu_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept, bad, timeout;
  logic        in_req, store_done, load_done, tmo_hit;
  logic [1:0]  off_d;
  logic [3:0]  be;
  logic [31:0] wrep, rext;

  assign accept = req_valid_i & req_ready_o;

`ifdef LSU_MISALIGN_TRAP_EN
  assign bad   = f3_illegal(req_store_i, req_func3_i) |
                 misaligned(req_func3_i, req_addr_i[1:0]);
  assign off_d = req_addr_i[1:0];
`else
  assign bad   = f3_illegal(req_store_i, req_func3_i);
  assign off_d = force_align(req_func3_i, req_addr_i[1:0]);
`endif

  // Last allowed cycle of REQ+WAIT; >= also catches a late grant.
  assign timeout = cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_align u_align (
    .func3     (f3_q),
    .off       (addr_q[1:0]),
    .wdata     (wdata_q),
    .rword     (bus.mem_rdata_i),
    .be        (be),
    .wdata_rep (wrep),
    .rdata_ext (rext)
  );

  assign in_req     = state_q == REQ;
  assign store_done = in_req & bus.mem_gnt_i & store_q;
  assign load_done  = (state_q == WAIT) & bus.mem_rvalid_i;
  assign tmo_hit    = timeout &
    ((in_req & ~bus.mem_gnt_i) |
     ((state_q == WAIT) & ~bus.mem_rvalid_i));

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: if (accept) state_d = bad ? RESP : REQ;
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_gnt_i)
          state_d = store_q ? RESP : WAIT;
        else if (timeout)
          state_d = RESP;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.mem_rvalid_i | timeout)
          state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      store_q <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        store_q <= req_store_i;
        f3_q    <= req_func3_i;
        addr_q  <= {req_addr_i[31:2], off_d};
        wdata_q <= req_wdata_i;
        err_q   <= bad;
        if (bad) rdata_q <= '0;
      end
      if (store_done) rdata_q <= '0;
      if (load_done)  rdata_q <= rext;
      if (tmo_hit) begin
        err_q   <= 1'b1;
        rdata_q <= '0;
      end
    end
  end

  assign req_ready_o  = (state_q == IDLE) & ~rst;
  assign resp_valid_o = state_q == RESP;
  assign bus_err_o    = resp_valid_o & err_q;
  assign resp_rdata_o = rdata_q;

  assign bus.mem_req_o   = in_req;
  assign bus.mem_we_o    = in_req & store_q;
  assign bus.mem_addr_o  = in_req ? addr_q[31:2] : '0;
  assign bus.mem_be_o    = in_req ? be : '0;
  assign bus.mem_wdata_o = in_req ? wrep : '0;

endmodule

// File: tb/tb_lsu_bus_master.sv
// Scoreboard bench for lsu_bus_master: responder model on the bus,
// expected responses queued at issue and checked on resp_valid_o.
module tb_lsu_bus_master;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, bus_err;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  lsu_bus_master_if bus ();

  lsu_bus_master #(
    .TIMEOUT_CYCLES (16),
    .CNT_W          (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_store_i  (req_store),
    .req_func3_i  (req_func3),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (resp_valid),
    .resp_rdata_o (resp_rdata),
    .bus_err_o    (bus_err),
    .bus          (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        got, o_err, saw_req, stable, rdy_hi;
  int          lat;
  logic [31:0] o_rdata;
  logic [29:0] c_addr;
  logic [3:0]  c_be;
  logic [31:0] c_wdata;
  logic        c_we;

  function automatic int m_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3,
                                      input logic [1:0] o);
    logic [3:0] r;
    int sz;
    sz = m_size(f3);
    r  = '0;
    for (int i = 0; i < 4; i++)
      if (i >= int'(o) && i < int'(o) + sz) r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] d);
    logic [31:0] r;
    int sz;
    sz = m_size(f3);
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = d[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [1:0] o,
                                         input logic [31:0] w);
    logic [31:0] v, msk;
    int sz;
    sz = m_size(f3);
    if (sz == 4) return w;
    v   = w >> (8 * int'(o));
    msk = (32'h1 << (8 * sz)) - 32'h1;
    v   = v & msk;
    if (!f3[2] && v[8*sz-1]) v = v | ~msk;
    return v;
  endfunction

  task automatic run_access(input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int gd, input int rd,
                            input logic [31:0] word, input logic poke);
    int gcyc;
    got = 0; lat = 0; o_rdata = '0; o_err = 0;
    saw_req = 0; stable = 1; rdy_hi = 0;
    c_addr = '0; c_be = '0; c_wdata = '0; c_we = 0;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_wait got 0 exp 1");
    end
    req_valid = 1; req_store = st; req_func3 = f3;
    req_addr = a; req_wdata = wd;
    @(negedge clk);
    if (poke) req_addr = a ^ 32'h100;
    else req_valid = 0;
    gcyc = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
      bus.mem_rdata_i = 32'hDEAD_BEEF;
      if (resp_valid) begin
        got = 1; lat = cyc; o_rdata = resp_rdata; o_err = bus_err;
        break;
      end
      if (req_ready) rdy_hi = 1;
      if (bus.mem_req_o) begin
        if (!saw_req) begin
          saw_req = 1;
          c_addr = bus.mem_addr_o; c_be = bus.mem_be_o;
          c_wdata = bus.mem_wdata_o; c_we = bus.mem_we_o;
        end else if ({c_addr, c_be, c_wdata, c_we} !==
                     {bus.mem_addr_o, bus.mem_be_o,
                      bus.mem_wdata_o, bus.mem_we_o})
          stable = 0;
        if (gd >= 0 && cyc - 1 == gd) begin
          bus.mem_gnt_i = 1; gcyc = cyc;
        end
      end else if (gcyc > 0 && !st && cyc == gcyc + 1 + rd) begin
        bus.mem_rvalid_i = 1; bus.mem_rdata_i = word;
      end
      @(negedge clk);
    end
    req_valid = 0; bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0;
  endtask

  task automatic test_reset;
    rst = 1; req_valid = 0; req_store = 0; req_func3 = '0;
    req_addr = '0; req_wdata = '0;
    bus.mem_gnt_i = 0; bus.mem_rvalid_i = 0; bus.mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_ready got %b exp 0", req_ready);
    end
    n_cmp++;
    if ({bus.mem_req_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_be_o,
         bus.mem_wdata_o} !== 68'h0) begin
      n_bad++; $display("FAIL rst_mem got nonzero exp 0");
    end
    n_cmp++;
    if ({resp_valid, bus_err, resp_rdata} !== 34'h0) begin
      n_bad++; $display("FAIL rst_resp got %b/%b/%h exp 0",
                        resp_valid, bus_err, resp_rdata);
    end
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_bad++; $display("FAIL rst_release_ready got %b exp 1", req_ready);
    end
  endtask

  task automatic test_store_byte;
    exp_t e;
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
    run_access(1, F3_B, 32'h7, 32'hA5, 0, 0, 32'h0, 0);
    e = sb.pop_front();
    n_cmp++;
    if ({got, lat, o_err, o_rdata} !== {1'b1, e.lat, e.err, e.rdata}) begin
      n_bad++; $display("FAIL sb_resp got %b/%0d/%b/%h exp 1/%0d/%b/%h",
                        got, lat, o_err, o_rdata, e.lat, e.err, e.rdata);
    end
    n_cmp++;
    if ({c_addr, c_be, c_wdata, c_we} !==
        {30'd1, 4'b1000, 32'hA5A5A5A5, 1'b1}) begin
      n_bad++; $display("FAIL sb_bus got %h/%b/%h/%b exp 1/1000/a5a5a5a5/1",
                        c_addr, c_be, c_wdata, c_we);
    end
  endtask

  task automatic test_load_ext;
    logic [2:0]  f3s [4] = '{F3_H, F3_HU, F3_B, F3_BU};
    logic [31:0] ads [4] = '{32'h6, 32'h6, 32'h1, 32'h1};
    logic [31:0] wds [4] = '{32'h80FF1234, 32'h80FF1234,
                             32'h0000F700, 32'h0000F700};
    logic [31:0] exs [4] = '{32'hFFFF80FF, 32'h000080FF,
                             32'hFFFFFFF7, 32'h000000F7};
    logic [3:0]  bes [4] = '{4'b1100, 4'b1100, 4'b0010, 4'b0010};
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{rdata: exs[i], err: 1'b0, lat: 3});
      run_access(0, f3s[i], ads[i], 32'h0, 0, 0, wds[i], 0);
      e = sb.pop_front();
      n_cmp++;
      if ({got, lat, o_err, o_rdata} !== {1'b1, e.lat, e.err, e.rdata}) begin
        n_bad++; $display("FAIL load_%0d got %b/%0d/%b/%h exp 1/%0d/%b/%h",
                          i, got, lat, o_err, o_rdata, e.lat, e.err, e.rdata);
      end
      n_cmp++;
      if ({c_be, c_we} !== {bes[i], 1'b0}) begin
        n_bad++; $display("FAIL load_be_%0d got %b/%b exp %b/0",
                          i, c_be, c_we, bes[i]);
      end
    end
  endtask

  task automatic test_holdoff;
    exp_t e;
    logic extra;
    sb.push_back('{rdata: 32'h0, err: 1'b0, lat: 7});
    run_access(1, F3_W, 32'h0000_1230, 32'hCAFE_F00D, 5, 0, 32'h0, 1);
    e = sb.pop_front();
    n_cmp++;
    if ({got, lat, o_err} !== {1'b1, e.lat, e.err}) begin
      n_bad++; $display("FAIL hold_resp got %b/%0d/%b exp 1/%0d/%b",
                        got, lat, o_err, e.lat, e.err);
    end
    n_cmp++;
    if ({stable, rdy_hi} !== 2'b10) begin
      n_bad++; $display("FAIL hold_stable got %b/%b exp 1/0", stable, rdy_hi);
    end
    n_cmp++;
    if ({c_addr, c_be, c_wdata} !== {30'h48C, 4'b1111, 32'hCAFE_F00D}) begin
      n_bad++; $display("FAIL hold_bus got %h/%b/%h exp 48c/1111/cafef00d",
                        c_addr, c_be, c_wdata);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid | bus.mem_req_o) extra = 1;
    end
    n_cmp++;
    if (extra !== 1'b0) begin
      n_bad++; $display("FAIL hold_poke_ignored got %b exp 0", extra);
    end
  endtask

  task automatic test_timeout;
    exp_t e;
    logic extra;
    sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 17});
    run_access(0, F3_W, 32'h0000_0100, 32'h0, -1, 0, 32'h0, 0);
    e = sb.pop_front();
    n_cmp++;
    if ({got, lat, o_err, o_rdata} !== {1'b1, e.lat, e.err, e.rdata}) begin
      n_bad++; $display("FAIL tmo_resp got %b/%0d/%b/%h exp 1/%0d/%b/%h",
                        got, lat, o_err, o_rdata, e.lat, e.err, e.rdata);
    end
    n_cmp++;
    if ({saw_req, bus.mem_req_o} !== 2'b10) begin
      n_bad++; $display("FAIL tmo_req got %b/%b exp 1/0", saw_req, bus.mem_req_o);
    end
    @(negedge clk);
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    bus.mem_rvalid_i = 0;
    extra = 0;
    repeat (3) begin
      if (resp_valid) extra = 1;
      @(negedge clk);
    end
    n_cmp++;
    if ({extra, resp_rdata} !== 33'h0) begin
      n_bad++; $display("FAIL tmo_late_rvalid got %b/%h exp 0/0", extra, resp_rdata);
    end
  endtask

  task automatic test_illegal;
    logic        sts [2] = '{1'b0, 1'b1};
    logic [2:0]  f3s [2] = '{3'b011, 3'b100};
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
      run_access(sts[i], f3s[i], 32'h40, 32'h55, 0, 0, 32'hFFFF_FFFF, 0);
      e = sb.pop_front();
      n_cmp++;
      if ({got, lat, o_err, saw_req} !== {1'b1, e.lat, e.err, 1'b0}) begin
        n_bad++; $display("FAIL illegal_%0d got %b/%0d/%b/%b exp 1/%0d/%b/0",
                          i, got, lat, o_err, saw_req, e.lat, e.err);
      end
    end
  endtask

  task automatic test_misalign;
    exp_t e;
`ifdef LSU_MISALIGN_TRAP_EN
    sb.push_back('{rdata: 32'h0, err: 1'b1, lat: 1});
`else
    sb.push_back('{rdata: 32'h1122_3344, err: 1'b0, lat: 3});
`endif
    run_access(0, F3_W, 32'h2, 32'h0, 0, 0, 32'h1122_3344, 0);
    e = sb.pop_front();
    n_cmp++;
    if ({got, lat, o_err, o_rdata} !== {1'b1, e.lat, e.err, e.rdata}) begin
      n_bad++; $display("FAIL misalign got %b/%0d/%b/%h exp 1/%0d/%b/%h",
                        got, lat, o_err, o_rdata, e.lat, e.err, e.rdata);
    end
`ifdef LSU_MISALIGN_TRAP_EN
    n_cmp++;
    if (saw_req !== 1'b0) begin
      n_bad++; $display("FAIL misalign_noreq got %b exp 0", saw_req);
    end
`else
    n_cmp++;
    if ({c_addr, c_be} !== {30'd0, 4'b1111}) begin
      n_bad++; $display("FAIL misalign_bus got %h/%b exp 0/1111", c_addr, c_be);
    end
`endif
  endtask

  task automatic test_reset_mid;
    exp_t e;
    logic extra;
    for (int k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    req_valid = 1; req_store = 0; req_func3 = F3_W; req_addr = 32'h80;
    @(negedge clk);
    req_valid = 0;
    bus.mem_gnt_i = 1;
    @(negedge clk);
    bus.mem_gnt_i = 0;
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if ({bus.mem_req_o, resp_valid, req_ready} !== 3'b000) begin
      n_bad++; $display("FAIL rstmid got %b/%b/%b exp 0/0/0",
                        bus.mem_req_o, resp_valid, req_ready);
    end
    bus.mem_rvalid_i = 1; bus.mem_rdata_i = 32'hAAAA_5555;
    @(negedge clk);
    bus.mem_rvalid_i = 0; rst = 0;
    extra = 0;
    repeat (4) begin
      if (resp_valid | bus.mem_req_o) extra = 1;
      @(negedge clk);
    end
    n_cmp++;
    if (extra !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_noresp got %b exp 0", extra);
    end
    sb.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0, lat: 3});
    run_access(0, F3_W, 32'h84, 32'h0, 0, 0, 32'h0BAD_F00D, 0);
    e = sb.pop_front();
    n_cmp++;
    if ({got, lat, o_err, o_rdata} !== {1'b1, e.lat, e.err, e.rdata}) begin
      n_bad++; $display("FAIL rstmid_fresh got %b/%0d/%b/%h exp 1/%0d/%b/%h",
                        got, lat, o_err, o_rdata, e.lat, e.err, e.rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  ld_f3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    exp_t e;
    for (int i = 0; i < 12; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [1:0]  o;
      logic [31:0] a, wd, word;
      int          gd, rd, sz;
      st   = 1'($urandom_range(0, 1));
      f3   = st ? ld_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      sz   = m_size(f3);
      o    = 2'($urandom_range(0, 3));
      o    = (sz == 4) ? 2'b00 : (sz == 2) ? {o[1], 1'b0} : o;
      a    = {$urandom, 2'b00} | 32'(o);
      wd   = $urandom;
      word = $urandom;
      gd   = $urandom_range(0, 2);
      rd   = $urandom_range(0, 2);
      sb.push_back('{rdata: st ? 32'h0 : m_load(f3, o, word), err: 1'b0,
                     lat: st ? 2 + gd : 3 + gd + rd});
      run_access(st, f3, a, wd, gd, rd, word, 0);
      e = sb.pop_front();
      n_cmp++;
      if ({got, lat, o_err, o_rdata} !== {1'b1, e.lat, e.err, e.rdata}) begin
        n_bad++; $display("FAIL b2b_%0d got %b/%0d/%b/%h exp 1/%0d/%b/%h",
                          i, got, lat, o_err, o_rdata, e.lat, e.err, e.rdata);
      end
      n_cmp++;
      if ({c_addr, c_be, c_we} !== {a[31:2], m_be(f3, o), st}) begin
        n_bad++; $display("FAIL b2b_bus_%0d got %h/%b/%b exp %h/%b/%b",
                          i, c_addr, c_be, c_we, a[31:2], m_be(f3, o), st);
      end
      if (st) begin
        n_cmp++;
        if (c_wdata !== m_wdata(f3, wd)) begin
          n_bad++; $display("FAIL b2b_wdata_%0d got %h exp %h",
                            i, c_wdata, m_wdata(f3, wd));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_load_ext();
    test_holdoff();
    test_timeout();
    test_illegal();
    test_misalign();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
